// File: rtl/tx_encoder.sv
// tx_encoder: IEEE 802.3 clause 36 8b/10b transmit encoder with registered output.
// Optional SKP ordered-set insertion (COM + SKP_COUNT x K28.0 every SKP_INTERVAL
// accepted symbols) is built only when the macro TX_SKP_INSERT_EN is defined;
// otherwise Ready_out is tied high and the SKP parameters are unused.
module tx_encoder #(
    parameter int SKP_INTERVAL = 1180,
    parameter int SKP_COUNT    = 3
) (
    input  logic       WordClk,
    input  logic       Rst,
    input  logic [7:0] Data_in,
    input  logic       DataK_in,
    input  logic       Valid_in,
    output logic       Ready_out,
    output logic [9:0] Data_out,
    output logic       Valid_out,
    output logic       RD_out,
    output logic       Code_Error
);

    // Symbol presented to the encoder this cycle (input or inserted).
    logic       w_emit;
    logic [7:0] w_sym;
    logic       w_sym_k;
    logic       w_ready;

    // Output / running-disparity registers.
    logic [9:0] r_data_out;
    logic       r_valid_out;
    logic       r_rd;
    logic       r_code_err;

`ifdef TX_SKP_INSERT_EN
    typedef enum logic [1:0] {S_DATA, S_SKP_COM, S_SKP_SYM} state_t;

    localparam int CNT_W = (SKP_INTERVAL < 1) ? 1 : $clog2(SKP_INTERVAL + 1);
    localparam int SKP_W = (SKP_COUNT < 2) ? 1 : $clog2(SKP_COUNT);
    localparam logic [CNT_W-1:0] INTERVAL_M1 = CNT_W'(SKP_INTERVAL - 1);
    localparam logic [SKP_W-1:0] SKP_LAST    = SKP_W'(SKP_COUNT - 1);

    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_sym_cnt;
    logic [SKP_W-1:0] r_skp_cnt;

    // State register plus accepted-symbol and inserted-SKP counters.
    always_ff @(posedge WordClk) begin
        // NOTE: non-blocking assignments keep every register sampling pre-edge values.
        if (Rst) begin
            r_state   <= S_DATA;
            r_sym_cnt <= '0;
            r_skp_cnt <= '0;
        end else begin
            r_state <= w_state_next;
            if (r_state == S_DATA && Valid_in)
                r_sym_cnt <= r_sym_cnt + 1'b1;
            else if (r_state != S_DATA && w_state_next == S_DATA)
                r_sym_cnt <= '0;
            if (r_state == S_SKP_SYM)
                r_skp_cnt <= r_skp_cnt + 1'b1;
            else
                r_skp_cnt <= '0;
        end
    end

    // Next-state decode: insertion starts after the interval-th accepted symbol.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_DATA:    if (Valid_in && r_sym_cnt == INTERVAL_M1) w_state_next = S_SKP_COM;
            S_SKP_COM: w_state_next = (SKP_COUNT == 0) ? S_DATA : S_SKP_SYM;
            S_SKP_SYM: if (r_skp_cnt == SKP_LAST) w_state_next = S_DATA;
            default:   w_state_next = S_DATA;
        endcase
    end

    // Output decode: ready only in DATA; inserted symbols replace the input.
    always_comb begin
        w_ready = 1'b0;
        w_emit  = 1'b0;
        w_sym   = Data_in;
        w_sym_k = DataK_in;
        case (r_state)
            S_DATA: begin
                w_ready = 1'b1;
                w_emit  = Valid_in;
            end
            S_SKP_COM: begin
                w_emit  = 1'b1;
                w_sym   = 8'hBC;
                w_sym_k = 1'b1;
            end
            S_SKP_SYM: begin
                w_emit  = 1'b1;
                w_sym   = 8'h1C;
                w_sym_k = 1'b1;
            end
            default: ;
        endcase
    end
`else
    logic [31:0] w_unused_skp;
    assign w_unused_skp = SKP_INTERVAL + SKP_COUNT;

    assign w_ready = 1'b1;
    assign w_emit  = Valid_in;
    assign w_sym   = Data_in;
    assign w_sym_k = DataK_in;
`endif

    logic [4:0] w_x;
    logic [2:0] w_y;
    logic       w_k28;
    logic       w_k_legal;
    logic [5:0] w_6b_neg;
    logic [5:0] w_6b;
    logic       w_6b_unbal;
    logic       w_rd_mid;
    logic       w_use_a7;
    logic [3:0] w_4b_neg;
    logic [3:0] w_4b;
    logic       w_4b_unbal;
    logic       w_flip4;
    logic       w_rd_next;
    logic [9:0] w_code;
    logic       w_code_err;

    // 5b/6b and 3b/4b encode; tables hold the RD- form, RD+ forms are complements.
    always_comb begin
        // NOTE: every comb output gets a default first so no path infers a latch.
        w_x        = w_sym[4:0];
        w_y        = w_sym[7:5];
        w_k28      = w_sym_k && (w_x == 5'd28);
        w_k_legal  = w_k28 || (w_sym_k && w_y == 3'd7 &&
                     (w_x == 5'd23 || w_x == 5'd27 || w_x == 5'd29 || w_x == 5'd30));
        w_code_err = w_sym_k && !w_k_legal;

        // 6b code written as abcdei with a in the MSB.
        case (w_x)
            5'd0:  w_6b_neg = 6'b100111;  5'd1:  w_6b_neg = 6'b011101;
            5'd2:  w_6b_neg = 6'b101101;  5'd3:  w_6b_neg = 6'b110001;
            5'd4:  w_6b_neg = 6'b110101;  5'd5:  w_6b_neg = 6'b101001;
            5'd6:  w_6b_neg = 6'b011001;  5'd7:  w_6b_neg = 6'b111000;
            5'd8:  w_6b_neg = 6'b111001;  5'd9:  w_6b_neg = 6'b100101;
            5'd10: w_6b_neg = 6'b010101;  5'd11: w_6b_neg = 6'b110100;
            5'd12: w_6b_neg = 6'b001101;  5'd13: w_6b_neg = 6'b101100;
            5'd14: w_6b_neg = 6'b011100;  5'd15: w_6b_neg = 6'b010111;
            5'd16: w_6b_neg = 6'b011011;  5'd17: w_6b_neg = 6'b100011;
            5'd18: w_6b_neg = 6'b010011;  5'd19: w_6b_neg = 6'b110010;
            5'd20: w_6b_neg = 6'b001011;  5'd21: w_6b_neg = 6'b101010;
            5'd22: w_6b_neg = 6'b011010;  5'd23: w_6b_neg = 6'b111010;
            5'd24: w_6b_neg = 6'b110011;  5'd25: w_6b_neg = 6'b100110;
            5'd26: w_6b_neg = 6'b010110;  5'd27: w_6b_neg = 6'b110110;
            5'd28: w_6b_neg = w_k28 ? 6'b001111 : 6'b001110;
            5'd29: w_6b_neg = 6'b101110;  5'd30: w_6b_neg = 6'b011110;
            default: w_6b_neg = 6'b101011;
        endcase
        w_6b_unbal = ($countones(w_6b_neg) != 3);
        // D.7 is balanced but still has distinct RD-/RD+ forms.
        w_6b     = (r_rd && (w_6b_unbal || w_x == 5'd7)) ? ~w_6b_neg : w_6b_neg;
        w_rd_mid = r_rd ^ w_6b_unbal;

        // Alternate x.7 avoids a run of five equal bits across the sub-blocks.
        w_use_a7 = w_k_legal ||
                   (!r_rd && (w_x == 5'd17 || w_x == 5'd18 || w_x == 5'd20)) ||
                   ( r_rd && (w_x == 5'd11 || w_x == 5'd13 || w_x == 5'd14));

        // 4b code written as fghj with f in the MSB.
        case (w_y)
            3'd0:    w_4b_neg = 4'b1011;
            3'd1:    w_4b_neg = 4'b1001;
            3'd2:    w_4b_neg = 4'b0101;
            3'd3:    w_4b_neg = 4'b1100;
            3'd4:    w_4b_neg = 4'b1101;
            3'd5:    w_4b_neg = 4'b1010;
            3'd6:    w_4b_neg = 4'b0110;
            default: w_4b_neg = w_use_a7 ? 4'b0111 : 4'b1110;
        endcase
        w_4b_unbal = ($countones(w_4b_neg) != 2);
        // K28.1/.2/.5/.6 use the complemented balanced code after an RD- 6b block.
        w_flip4 = w_rd_mid ? (w_4b_unbal || w_y == 3'd3)
                           : (w_k28 && (w_y == 3'd1 || w_y == 3'd2 || w_y == 3'd5 || w_y == 3'd6));
        w_4b      = w_flip4 ? ~w_4b_neg : w_4b_neg;
        w_rd_next = w_rd_mid ^ w_4b_unbal;

        // Pack so that a lands in bit 0 and j in bit 9.
        w_code = {w_4b[0], w_4b[1], w_4b[2], w_4b[3],
                  w_6b[0], w_6b[1], w_6b[2], w_6b[3], w_6b[4], w_6b[5]};
    end

    // Output register: load on an emitted symbol, otherwise hold data and RD.
    always_ff @(posedge WordClk) begin
        if (Rst) begin
            r_data_out  <= '0;
            r_valid_out <= 1'b0;
            r_rd        <= 1'b0;
            r_code_err  <= 1'b0;
        end else if (w_emit) begin
            r_data_out  <= w_code;
            r_valid_out <= 1'b1;
            r_rd        <= w_rd_next;
            r_code_err  <= w_code_err;
        end else begin
            r_valid_out <= 1'b0;
            r_code_err  <= 1'b0;
        end
    end

    assign Ready_out  = w_ready;
    assign Data_out   = r_data_out;
    assign Valid_out  = r_valid_out;
    assign RD_out     = r_rd;
    assign Code_Error = r_code_err;

endmodule

// File: tb/tb_tx_encoder.sv
// tb_tx_encoder: directed-vector bench for tx_encoder with hand-computed 10b codes.
// SKP insertion checks apply when TX_SKP_INSERT_EN is defined; otherwise the
// bench confirms that no symbols are inserted and Ready_out stays high.
module tb_tx_encoder;

    logic       WordClk = 1'b0;
    logic       Rst = 1'b1;
    logic [7:0] Data_in = 8'h00;
    logic       DataK_in = 1'b0;
    logic       Valid_in = 1'b0;
    logic       Ready_out;
    logic [9:0] Data_out;
    logic       Valid_out;
    logic       RD_out;
    logic       Code_Error;

    int n_cmp = 0;
    int n_err = 0;

    tx_encoder #(.SKP_INTERVAL(8), .SKP_COUNT(3)) dut (
        .WordClk    (WordClk),
        .Rst        (Rst),
        .Data_in    (Data_in),
        .DataK_in   (DataK_in),
        .Valid_in   (Valid_in),
        .Ready_out  (Ready_out),
        .Data_out   (Data_out),
        .Valid_out  (Valid_out),
        .RD_out     (RD_out),
        .Code_Error (Code_Error)
    );

    always #5 WordClk = ~WordClk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge WordClk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input logic k);
        Data_in  = d;
        DataK_in = k;
        Valid_in = 1'b1;
        tick();
        Valid_in = 1'b0;
    endtask

    task automatic expect_sym(input string tag, input logic [9:0] code, input logic rd,
                              input logic cerr);
        check({tag, ".valid"}, 32'(Valid_out), 32'd1);
        check({tag, ".data"}, 32'(Data_out), 32'(code));
        check({tag, ".rd"}, 32'(RD_out), 32'(rd));
        check({tag, ".cerr"}, 32'(Code_Error), 32'(cerr));
    endtask

    task automatic do_reset(input string tag);
        Rst      = 1'b1;
        Valid_in = 1'b0;
        tick();
        check({tag, ".ready_in_rst"}, 32'(Ready_out), 32'd1);
        tick();
        check({tag, ".data"}, 32'(Data_out), 32'd0);
        check({tag, ".valid"}, 32'(Valid_out), 32'd0);
        check({tag, ".rd"}, 32'(RD_out), 32'd0);
        check({tag, ".cerr"}, 32'(Code_Error), 32'd0);
        Rst = 1'b0;
        check({tag, ".ready_after"}, 32'(Ready_out), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        do_reset("rst0");

        // K28.5 twice back-to-back from RD-.
        send(8'hBC, 1'b1);  expect_sym("k28_5_neg", 10'h17C, 1'b1, 1'b0);
        send(8'hBC, 1'b1);  expect_sym("k28_5_pos", 10'h283, 1'b0, 1'b0);

        // Idle cycle: valid drops, data and RD hold.
        tick();
        check("idle.valid", 32'(Valid_out), 32'd0);
        check("idle.data", 32'(Data_out), 32'h283);
        check("idle.rd", 32'(RD_out), 32'd0);

        // D21.5 is balanced: RD stays negative.
        send(8'hB5, 1'b0);  expect_sym("d21_5", 10'h155, 1'b0, 1'b0);

        // Illegal K 0x00 from RD-: D0.0 code, error for one output cycle.
        send(8'h00, 1'b1);  expect_sym("badk_neg", 10'h0B9, 1'b0, 1'b1);
        tick();
        check("badk_clr.cerr", 32'(Code_Error), 32'd0);
        check("badk_clr.valid", 32'(Valid_out), 32'd0);

        // Alternate x.7 selection in both disparities, and primary x.7.
        send(8'hBC, 1'b1);  expect_sym("k28_5_b", 10'h17C, 1'b1, 1'b0);
        send(8'hEB, 1'b0);  expect_sym("d11_7_pos", 10'h04B, 1'b0, 1'b0);
        send(8'hF1, 1'b0);  expect_sym("d17_7_neg", 10'h3B1, 1'b1, 1'b0);
        send(8'hE3, 1'b0);  expect_sym("d3_7_pos", 10'h223, 1'b0, 1'b0);

        // Legal K23.7, then D7.0 in both disparities.
        send(8'hF7, 1'b1);  expect_sym("k23_7", 10'h057, 1'b0, 1'b0);
        send(8'h07, 1'b0);  expect_sym("d7_0_neg", 10'h347, 1'b1, 1'b0);
        send(8'h07, 1'b0);  expect_sym("d7_0_pos", 10'h0B8, 1'b0, 1'b0);

        // Illegal K from RD+, then K28.0 from RD+.
        send(8'h07, 1'b0);  expect_sym("d7_0_neg2", 10'h347, 1'b1, 1'b0);
        send(8'h00, 1'b1);  expect_sym("badk_pos", 10'h346, 1'b1, 1'b1);
        send(8'h1C, 1'b1);  expect_sym("k28_0_pos", 10'h343, 1'b1, 1'b0);

        do_reset("rst1");

`ifdef TX_SKP_INSERT_EN
        // Continuous stream: 8 accepted bytes, then COM + 3 x K28.0 with ready low.
        Data_in  = 8'hB5;
        DataK_in = 1'b0;
        Valid_in = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("stream%0d.ready", i), 32'(Ready_out), 32'd1);
            tick();
            expect_sym($sformatf("stream%0d", i), 10'h155, 1'b0, 1'b0);
        end
        for (int j = 0; j < 4; j++) begin
            check($sformatf("skp%0d.ready", j), 32'(Ready_out), 32'd0);
            tick();
            if (j == 0) expect_sym("skp_com", 10'h17C, 1'b1, 1'b0);
            else        expect_sym($sformatf("skp_sym%0d", j), 10'h343, 1'b1, 1'b0);
        end
        // Counter restarts: 8 more bytes accepted before the next insertion.
        for (int i = 0; i < 8; i++) begin
            check($sformatf("restart%0d.ready", i), 32'(Ready_out), 32'd1);
            tick();
            expect_sym($sformatf("restart%0d", i), 10'h155, 1'b1, 1'b0);
        end
        check("restart.ready_low", 32'(Ready_out), 32'd0);

        // Reset in the middle of SKP_SYM aborts the insertion.
        do_reset("rst2");
        Valid_in = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        tick();
        expect_sym("abort_com", 10'h17C, 1'b1, 1'b0);
        tick();
        expect_sym("abort_sym1", 10'h343, 1'b1, 1'b0);
        Rst = 1'b1;
        tick();
        Rst      = 1'b0;
        Valid_in = 1'b0;
        check("abort.ready", 32'(Ready_out), 32'd1);
        check("abort.valid", 32'(Valid_out), 32'd0);
        check("abort.rd", 32'(RD_out), 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("abort_idle%0d.valid", i), 32'(Valid_out), 32'd0);
        end
`else
        // Without insertion, ready stays high and every byte is encoded in order.
        Data_in  = 8'hB5;
        DataK_in = 1'b0;
        Valid_in = 1'b1;
        for (int i = 0; i < 12; i++) begin
            check($sformatf("stream%0d.ready", i), 32'(Ready_out), 32'd1);
            tick();
            expect_sym($sformatf("stream%0d", i), 10'h155, 1'b0, 1'b0);
        end
        Valid_in = 1'b0;
        tick();
        check("stream_end.valid", 32'(Valid_out), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
